sysref_gen: RTL and testbench
=============================

SYSREF_GEN -- requirements
Module: sysref_gen

Interface
REQ-001 SHALL have parameter NCHAN, default 2, number of independent sysref outputs.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of period, high-time and phase fields.
REQ-003 SHALL have parameter BURST_WIDTH, default 8, width of burst count.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  single-cycle start strobe.
REQ-007 SHALL have port stop_i  input  1  single-cycle stop strobe.
REQ-008 SHALL have port mode_i  input  2  00 off, 01 continuous, 10 burst, 11 treated as off.
REQ-009 SHALL have port period_i  input  CNT_WIDTH  period length minus one (P).
REQ-010 SHALL have port high_i  input  CNT_WIDTH  high cycles per period (H).
REQ-011 SHALL have port phase_i  input  NCHAN*CNT_WIDTH  per-channel phase advance; channel c in bits [c*CNT_WIDTH +: CNT_WIDTH].
REQ-012 SHALL have port burst_i  input  BURST_WIDTH  burst length in periods (B).
REQ-013 SHALL have port sysref_o  output  NCHAN  registered sysref outputs.
REQ-014 SHALL have port period_o  output  1  registered strobe, high in output cycles where base position is 0.
REQ-015 SHALL have port busy_o  output  1  high while in RUN.
REQ-016 SHALL have port done_o  output  1  single-cycle burst-complete strobe.

Function
REQ-017 SHALL implement states IDLE and RUN; reset state IDLE.
REQ-018 SHALL, in IDLE on edge k sampling start_i=1 with mode 01 or 10, latch P, H, all phases, B and mode, and enter RUN; mode 00/11 stays IDLE.
REQ-019 SHALL ignore start_i while in RUN; latched configuration is unaffected by input changes during RUN.
REQ-020 SHALL keep one base counter (0..P, wraps to 0 after P) and one counter per channel, loaded at start with min(phase_c, P), same wrap rule.
REQ-021 SHALL drive, for n>=0 while running, sysref_o[c] at edge k+1+n = (((min(phase_c,P)+n) mod (P+1)) < H).
REQ-022 SHALL consequently hold output constant low for H=0 and constant high for H>P; P=0 gives period of one cycle.
REQ-023 SHALL drive period_o at edge k+1+n high exactly when (n mod (P+1)) = 0.
REQ-024 SHALL, in burst mode, run exactly Beff=max(B,1) periods: at edge k+1+Beff*(P+1) return to IDLE, sysref_o and period_o low, done_o high for that one cycle.
REQ-025 SHALL, in continuous mode, run until stop_i; done_o never asserted in continuous mode.
REQ-026 SHALL, on stop_i sampled in RUN, enter IDLE with all sysref_o, period_o, busy_o low from the next edge; done_o not asserted.
REQ-027 SHALL give stop_i priority when stop_i coincides with the burst-final edge (done_o not asserted).
REQ-028 SHALL drive busy_o = 1 from edge k+1 until the edge returning to IDLE (exclusive).
REQ-029 SHALL use a burst period counter of BURST_WIDTH bits that never wraps within a burst.
REQ-030 SHALL allow start_i on the cycle where done_o is high to begin a new run (outputs valid one edge later per REQ-021).

Reset
REQ-031 SHALL, on reset_i assertion, immediately (asynchronously) force sysref_o, period_o, busy_o, done_o to 0, state IDLE, all counters 0.
REQ-032 SHALL require a fresh start_i after reset_i deassertion; latched configuration is cleared to 0.

Verification
REQ-033 SHALL verify continuous: P=47, H=24, phases {0,0}, start -> both outputs 48-cycle period, 24 high from edge k+1, period_o every 48 cycles, aligned.
REQ-034 SHALL verify phase: P=47, H=24, phase1=5 -> channel 1 rises 5 cycles before channel 0 each period; phase1=60 -> clamped to 47.
REQ-035 SHALL verify burst: P=9, H=3, B=3 -> exactly 3 pulses of 3 cycles per output, done_o single cycle at k+31, busy_o low at k+31; B=0 -> 1 pulse.
REQ-036 SHALL verify stop/start: stop_i mid-high -> outputs low next edge, no done_o; start_i during RUN with new P -> ignored.
REQ-037 SHALL verify corners: H=0 -> constant low; H=P+1 -> constant high; P=0,H=1 -> constant high with period_o every cycle; mode 11 start -> stays IDLE.
REQ-038 SHALL verify reset: reset_i asserted mid-burst between clock edges -> all outputs 0 before next edge; no output until new start_i.

Source files
------------

// File: rtl/sysref_gen.sv
// Multi-channel SYSREF pulse generator: a shared base counter plus one phase-shifted
// counter per channel, run continuously or for a fixed number of periods.
module sysref_gen #(
    parameter int NCHAN       = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                       aclk,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [1:0]                 mode_i,
    input  logic [CNT_WIDTH-1:0]       period_i,
    input  logic [CNT_WIDTH-1:0]       high_i,
    input  logic [NCHAN*CNT_WIDTH-1:0] phase_i,
    input  logic [BURST_WIDTH-1:0]     burst_i,
    output logic [NCHAN-1:0]           sysref_o,
    output logic                       period_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [1:0]             MODE_CONT  = 2'b01;
    localparam logic [1:0]             MODE_BURST = 2'b10;
    localparam logic [CNT_WIDTH-1:0]   CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] BURST_ZERO = '0;
    localparam logic [BURST_WIDTH-1:0] BURST_ONE  = BURST_WIDTH'(1);

    state_t                 state_q, state_nxt;
    logic                   load, advance, finish;

    logic [CNT_WIDTH-1:0]   cfg_period, cfg_high;
    logic [BURST_WIDTH-1:0] cfg_beff;
    logic                   cfg_burst;

    logic [CNT_WIDTH-1:0]   base_cnt;
    logic [CNT_WIDTH-1:0]   ch_cnt [NCHAN];
    logic [BURST_WIDTH-1:0] burst_cnt;

    function automatic logic [CNT_WIDTH-1:0] wrap_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic [CNT_WIDTH-1:0] lim);
        return (cnt == lim) ? CNT_ZERO : cnt + CNT_ONE;
    endfunction

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, otherwise the
    // unassigned paths would infer latches.
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && (mode_i == MODE_CONT || mode_i == MODE_BURST)) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Stop wins over burst completion, so done is suppressed.
                if (stop_i) begin
                    state_nxt = IDLE;
                end else if (cfg_burst && base_cnt == CNT_ZERO && burst_cnt == cfg_beff) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the counters, so they lag the RUN state by one
    // edge: busy and the first sysref value appear on the edge after start.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            cfg_period <= CNT_ZERO;
            cfg_high   <= CNT_ZERO;
            cfg_beff   <= BURST_ZERO;
            cfg_burst  <= 1'b0;
            base_cnt   <= CNT_ZERO;
            burst_cnt  <= BURST_ZERO;
            // NOTE: the per-channel counters are plain flops, not a RAM, so they
            // can and must be cleared by the async reset like everything else.
            for (int c = 0; c < NCHAN; c++) ch_cnt[c] <= CNT_ZERO;
            sysref_o   <= '0;
            period_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            sysref_o <= '0;
            period_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= finish;

            if (load) begin
                cfg_period <= period_i;
                cfg_high   <= high_i;
                cfg_burst  <= (mode_i == MODE_BURST);
                cfg_beff   <= (burst_i == BURST_ZERO) ? BURST_ONE : burst_i;
                base_cnt   <= CNT_ZERO;
                burst_cnt  <= BURST_ZERO;
                for (int c = 0; c < NCHAN; c++) begin
                    ch_cnt[c] <= (phase_i[c*CNT_WIDTH +: CNT_WIDTH] > period_i)
                                 ? period_i : phase_i[c*CNT_WIDTH +: CNT_WIDTH];
                end
            end

            if (advance) begin
                busy_o   <= 1'b1;
                period_o <= (base_cnt == CNT_ZERO);
                base_cnt <= wrap_inc(base_cnt, cfg_period);
                for (int c = 0; c < NCHAN; c++) begin
                    sysref_o[c] <= (ch_cnt[c] < cfg_high);
                    ch_cnt[c]   <= wrap_inc(ch_cnt[c], cfg_period);
                end
                // Counts completed periods; bounded by cfg_beff so it never wraps.
                if (cfg_burst && base_cnt == cfg_period) burst_cnt <= burst_cnt + BURST_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sysref_gen.sv
// Directed bench for sysref_gen: continuous, phase, burst, stop/start, corner and
// asynchronous reset scenarios, checked cycle by cycle with immediate assertions.
module tb_sysref_gen;

    localparam int NCHAN = 2;
    localparam int CW    = 16;
    localparam int BW    = 8;

    logic            aclk = 1'b0;
    logic            reset_i;
    logic            start_i, stop_i;
    logic [1:0]      mode_i;
    logic [CW-1:0]   period_i, high_i;
    logic [2*CW-1:0] phase_i;
    logic [BW-1:0]   burst_i;
    logic [1:0]      sysref_o;
    logic            period_o, busy_o, done_o;

    int n_checks = 0;
    int n_fails  = 0;

    sysref_gen #(.NCHAN(NCHAN), .CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .aclk     (aclk),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .mode_i   (mode_i),
        .period_i (period_i),
        .high_i   (high_i),
        .phase_i  (phase_i),
        .burst_i  (burst_i),
        .sysref_o (sysref_o),
        .period_o (period_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 aclk = ~aclk;

    // Observed vector layout: {done, busy, period, sysref[1], sysref[0]}
    function automatic logic [4:0] obs_vec();
        return {done_o, busy_o, period_o, sysref_o};
    endfunction

    // Expected vector n cycles into a run, straight from the output definition.
    function automatic logic [4:0] exp_vec(input int n, input int p, input int h,
                                           input int ph0, input int ph1);
        logic [4:0] r;
        int c0, c1;
        c0 = (ph0 > p) ? p : ph0;
        c1 = (ph1 > p) ? p : ph1;
        r[4] = 1'b0;
        r[3] = 1'b1;
        r[2] = ((n % (p + 1)) == 0);
        r[1] = (((c1 + n) % (p + 1)) < h);
        r[0] = (((c0 + n) % (p + 1)) < h);
        return r;
    endfunction

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_check(input string tag, input int n0, input int cnt, input int p,
                             input int h, input int ph0, input int ph1);
        for (int i = 0; i < cnt; i++) begin
            step();
            check(tag, obs_vec(), exp_vec(n0 + i, p, h, ph0, ph1));
        end
    endtask

    task automatic do_start(input logic [1:0] mode, input int p, input int h,
                            input int ph0, input int ph1, input int b);
        mode_i   = mode;
        period_i = CW'(p);
        high_i   = CW'(h);
        phase_i  = {CW'(ph1), CW'(ph0)};
        burst_i  = BW'(b);
        start_i  = 1'b1;
        step();
        start_i  = 1'b0;
        check("start_edge", obs_vec(), 5'b00000);
    endtask

    task automatic do_stop(input string tag);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check(tag, obs_vec(), 5'b00000);
        step();
        check(tag, obs_vec(), 5'b00000);
    endtask

    initial begin
        reset_i  = 1'b1;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        mode_i   = 2'b00;
        period_i = '0;
        high_i   = '0;
        phase_i  = '0;
        burst_i  = '0;

        // Reset state
        step();
        step();
        check("reset_state", obs_vec(), 5'b00000);
        reset_i = 1'b0;
        step();
        check("idle_after_reset", obs_vec(), 5'b00000);

        // Continuous, aligned channels
        do_start(2'b01, 47, 24, 0, 0, 0);
        run_check("cont_aligned", 0, 100, 47, 24, 0, 0);
        do_stop("cont_stop");

        // Phase advance; a start with new P during RUN must be ignored; stop mid-high
        do_start(2'b01, 47, 24, 0, 5, 0);
        run_check("phase5", 0, 20, 47, 24, 0, 5);
        start_i  = 1'b1;
        mode_i   = 2'b10;
        period_i = 16'd9;
        run_check("start_in_run", 20, 1, 47, 24, 0, 5);
        start_i  = 1'b0;
        run_check("phase5", 21, 40, 47, 24, 0, 5);
        do_stop("stop_mid_high");

        // Phase clamp to P
        do_start(2'b01, 47, 24, 0, 60, 0);
        run_check("phase_clamp", 0, 50, 47, 24, 0, 60);
        do_stop("clamp_stop");

        // Burst of 3 periods
        do_start(2'b10, 9, 3, 0, 0, 3);
        run_check("burst3", 0, 30, 9, 3, 0, 0);
        step();
        check("burst3_done", obs_vec(), 5'b10000);
        step();
        check("burst3_after", obs_vec(), 5'b00000);

        // B=0 runs one period; restart on the done cycle
        do_start(2'b10, 9, 3, 0, 0, 0);
        run_check("burst0", 0, 10, 9, 3, 0, 0);
        step();
        check("burst0_done", obs_vec(), 5'b10000);
        high_i  = 16'd5;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("restart_edge", obs_vec(), 5'b00000);
        run_check("restart_run", 0, 10, 9, 5, 0, 0);
        step();
        check("restart_done", obs_vec(), 5'b10000);

        // Corners
        do_start(2'b01, 5, 0, 2, 3, 0);
        run_check("h_zero", 0, 12, 5, 0, 2, 3);
        do_stop("h_zero_stop");
        do_start(2'b01, 5, 6, 2, 3, 0);
        run_check("h_full", 0, 12, 5, 6, 2, 3);
        do_stop("h_full_stop");
        do_start(2'b01, 0, 1, 0, 4, 0);
        run_check("p_zero", 0, 5, 0, 1, 0, 4);
        do_stop("p_zero_stop");
        do_start(2'b11, 9, 3, 0, 0, 2);
        step();
        check("mode11_idle", obs_vec(), 5'b00000);
        do_start(2'b00, 9, 3, 0, 0, 2);
        step();
        check("mode00_idle", obs_vec(), 5'b00000);

        // Asynchronous reset mid-burst, then no activity without a new start
        do_start(2'b10, 9, 3, 0, 0, 3);
        run_check("pre_reset", 0, 12, 9, 3, 0, 0);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_reset", obs_vec(), 5'b00000);
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_idle", obs_vec(), 5'b00000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
